// File: rtl/rs_station_pkg.sv
// -----------------------------------------------------------------------------
// rs_station_pkg
// Shared definitions for the reservation station slice:
//   - ROB_TAG_READY : tag value meaning "no dependency / operand present"
//   - default geometry for the station (entry count, ROB tag width, etc.)
//   - opcode encodings carried through the station to the function units
// Optional feature macro used by importing files: RS_AGE_PICK_EN
// -----------------------------------------------------------------------------
package rs_station_pkg;

   // A producer tag of zero means the operand value is already valid.
   localparam int ROB_TAG_READY     = 0;

   localparam int RS_ENTRY_NUM_DEF  = 8;
   localparam int ROB_ENTRY_WIDTH   = 4;
   localparam int RS_DATA_WIDTH_DEF = 32;
   localparam int RS_OP_WIDTH_DEF   = 6;
   localparam int RS_CDB_NUM_DEF    = 2;

   typedef enum logic [5:0] {
      OP_NOP = 6'h00,
      OP_ADD = 6'h01,
      OP_SUB = 6'h02,
      OP_AND = 6'h03,
      OP_OR  = 6'h04,
      OP_XOR = 6'h05,
      OP_SLT = 6'h06,
      OP_LD  = 6'h07,
      OP_ST  = 6'h08,
      OP_BEQ = 6'h09
   } rs_opcode_e;

endpackage

// File: rtl/rs_select.sv
// -----------------------------------------------------------------------------
// rs_select
// Combinational picker for the reservation station. Chooses one ready entry.
//   Default build       : lowest ready index wins.
//   RS_AGE_PICK_EN set  : ready entry with the smallest age rank (oldest) wins.
// Ports:
//   i_ready  [ENTRY_NUM]            per-entry ready bits
//   i_rank   [ENTRY_NUM*IDX_W]      packed age ranks (RS_AGE_PICK_EN only)
//   o_grant  [ENTRY_NUM]            one-hot grant (all zero when none ready)
//   o_idx    [IDX_W]                index of the granted entry
//   o_valid  1                      some entry is ready
// -----------------------------------------------------------------------------
module rs_select
   import rs_station_pkg::*;
#(
   parameter int ENTRY_NUM = RS_ENTRY_NUM_DEF
) (
   input  logic [ENTRY_NUM-1:0]                   i_ready,
`ifdef RS_AGE_PICK_EN
   input  logic [ENTRY_NUM*$clog2(ENTRY_NUM)-1:0] i_rank,
`endif
   output logic [ENTRY_NUM-1:0]                   o_grant,
   output logic [$clog2(ENTRY_NUM)-1:0]           o_idx,
   output logic                                   o_valid
);

   localparam int IDX_W = $clog2(ENTRY_NUM);

`ifdef RS_AGE_PICK_EN
   logic [IDX_W-1:0] w_best_rank;
   logic [IDX_W-1:0] w_rank_i;

   // Ranks of busy entries are unique, so the strict compare only matters
   // for robustness; ties would fall to the lower index.
   always_comb begin
      // NOTE: every combinational output gets a default before the loop so no latch is inferred.
      o_valid     = 1'b0;
      o_idx       = '0;
      w_best_rank = '1;
      w_rank_i    = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
         w_rank_i = i_rank[i*IDX_W +: IDX_W];
         if (i_ready[i] && (!o_valid || (w_rank_i < w_best_rank))) begin
            o_valid     = 1'b1;
            o_idx       = IDX_W'(i);
            w_best_rank = w_rank_i;
         end
      end
   end
`else
   // Scan from the top down so the lowest ready index is the last writer.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (i_ready[i]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(i);
         end
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         o_grant[i] = o_valid && (o_idx == IDX_W'(i));
      end
   end

endmodule

// File: rtl/rs_station.sv
// -----------------------------------------------------------------------------
// rs_station
// Reservation station for the Tomasulo core. Holds issued ops until both
// source operands are resolved (via issue-time values or CDB snooping) and
// dispatches one ready op per cycle into a registered valid/ready output.
// Optional feature macro: RS_AGE_PICK_EN (oldest-first selection by age rank).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               discard all entries and the output register
//   issue_valid/ready   issue handshake; ready = station not full
//   issue_op/vj/vk      opcode and operand values
//   issue_qj/qk         producer ROB tags (0 = value present)
//   issue_dest          destination ROB tag
//   cdb_valid/tag/data  CDB_NUM packed result broadcasts
//   fu_valid/ready      dispatch handshake to the function unit
//   fu_op/vj/vk/dest    dispatched op
//   count               number of busy entries
// -----------------------------------------------------------------------------
module rs_station
   import rs_station_pkg::*;
#(
   parameter int ENTRY_NUM  = RS_ENTRY_NUM_DEF,
   parameter int ROB_WIDTH  = ROB_ENTRY_WIDTH,
   parameter int DATA_WIDTH = RS_DATA_WIDTH_DEF,
   parameter int OP_WIDTH   = RS_OP_WIDTH_DEF,
   parameter int CDB_NUM    = RS_CDB_NUM_DEF
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            issue_valid,
   output logic                            issue_ready,
   input  logic [OP_WIDTH-1:0]             issue_op,
   input  logic [DATA_WIDTH-1:0]           issue_vj,
   input  logic [DATA_WIDTH-1:0]           issue_vk,
   input  logic [ROB_WIDTH-1:0]            issue_qj,
   input  logic [ROB_WIDTH-1:0]            issue_qk,
   input  logic [ROB_WIDTH-1:0]            issue_dest,
   input  logic [CDB_NUM-1:0]              cdb_valid,
   input  logic [CDB_NUM*ROB_WIDTH-1:0]    cdb_tag,
   input  logic [CDB_NUM*DATA_WIDTH-1:0]   cdb_data,
   output logic                            fu_valid,
   input  logic                            fu_ready,
   output logic [OP_WIDTH-1:0]             fu_op,
   output logic [DATA_WIDTH-1:0]           fu_vj,
   output logic [DATA_WIDTH-1:0]           fu_vk,
   output logic [ROB_WIDTH-1:0]            fu_dest,
   output logic [$clog2(ENTRY_NUM+1)-1:0]  count
);

   localparam int IDX_W = $clog2(ENTRY_NUM);
   localparam int CNT_W = $clog2(ENTRY_NUM + 1);
   localparam logic [ROB_WIDTH-1:0] TAG_RDY = ROB_WIDTH'(ROB_TAG_READY);

   // ---------------------------------------------------------------- state
   logic [ENTRY_NUM-1:0]  r_busy;
   logic [OP_WIDTH-1:0]   r_op   [ENTRY_NUM];
   logic [DATA_WIDTH-1:0] r_vj   [ENTRY_NUM];
   logic [DATA_WIDTH-1:0] r_vk   [ENTRY_NUM];
   logic [ROB_WIDTH-1:0]  r_qj   [ENTRY_NUM];
   logic [ROB_WIDTH-1:0]  r_qk   [ENTRY_NUM];
   logic [ROB_WIDTH-1:0]  r_dest [ENTRY_NUM];
   logic [CNT_W-1:0]      r_count;

   logic                  r_fu_valid;
   logic [OP_WIDTH-1:0]   r_fu_op;
   logic [DATA_WIDTH-1:0] r_fu_vj;
   logic [DATA_WIDTH-1:0] r_fu_vk;
   logic [ROB_WIDTH-1:0]  r_fu_dest;

   // ---------------------------------------------------------------- CDB unpack
   logic [ROB_WIDTH-1:0]  w_cdb_tag  [CDB_NUM];
   logic [DATA_WIDTH-1:0] w_cdb_data [CDB_NUM];

   always_comb begin
      for (int c = 0; c < CDB_NUM; c++) begin
         w_cdb_tag[c]  = cdb_tag[c*ROB_WIDTH +: ROB_WIDTH];
         w_cdb_data[c] = cdb_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // ---------------------------------------------------------------- issue-cycle bypass
   // An op whose producer broadcasts in the issue cycle would otherwise miss
   // the result forever, so the CDB is matched against the incoming tags too.
   // Channels are scanned top-down so the lowest matching channel wins.
   logic [ROB_WIDTH-1:0]  w_iss_qj, w_iss_qk;
   logic [DATA_WIDTH-1:0] w_iss_vj, w_iss_vk;

   always_comb begin
      w_iss_qj = issue_qj;
      w_iss_qk = issue_qk;
      w_iss_vj = issue_vj;
      w_iss_vk = issue_vk;
      for (int c = CDB_NUM - 1; c >= 0; c--) begin
         if (cdb_valid[c] && (w_cdb_tag[c] != TAG_RDY)) begin
            if (w_cdb_tag[c] == issue_qj) begin
               w_iss_qj = TAG_RDY;
               w_iss_vj = w_cdb_data[c];
            end
            if (w_cdb_tag[c] == issue_qk) begin
               w_iss_qk = TAG_RDY;
               w_iss_vk = w_cdb_data[c];
            end
         end
      end
   end

   // ---------------------------------------------------------------- wakeup
   logic [ENTRY_NUM-1:0]  w_wk_j_hit, w_wk_k_hit;
   logic [DATA_WIDTH-1:0] w_wk_j_data [ENTRY_NUM];
   logic [DATA_WIDTH-1:0] w_wk_k_data [ENTRY_NUM];

   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         w_wk_j_hit[i]  = 1'b0;
         w_wk_k_hit[i]  = 1'b0;
         w_wk_j_data[i] = '0;
         w_wk_k_data[i] = '0;
         for (int c = CDB_NUM - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (w_cdb_tag[c] != TAG_RDY)) begin
               if (w_cdb_tag[c] == r_qj[i]) begin
                  w_wk_j_hit[i]  = 1'b1;
                  w_wk_j_data[i] = w_cdb_data[c];
               end
               if (w_cdb_tag[c] == r_qk[i]) begin
                  w_wk_k_hit[i]  = 1'b1;
                  w_wk_k_data[i] = w_cdb_data[c];
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- allocation
   // Allocation looks only at registered Busy, so an entry freed by this
   // cycle's dispatch is not handed out again until the next cycle.
   logic [IDX_W-1:0] w_alloc_idx;
   logic             w_full;
   logic             w_issue;

   always_comb begin
      w_alloc_idx = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (!r_busy[i]) w_alloc_idx = IDX_W'(i);
      end
   end

   assign w_full      = &r_busy;
   assign issue_ready = !w_full;
   assign w_issue     = issue_valid && !w_full;

   // ---------------------------------------------------------------- selection
   logic [ENTRY_NUM-1:0] w_ready;
   logic [ENTRY_NUM-1:0] w_grant;
   logic [IDX_W-1:0]     w_sel_idx;
   logic                 w_sel_valid;
   logic                 w_load;

   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         w_ready[i] = r_busy[i] && (r_qj[i] == TAG_RDY) && (r_qk[i] == TAG_RDY);
      end
   end

   // Output register refills when empty or when the FU takes it this cycle.
   assign w_load = w_sel_valid && (!r_fu_valid || fu_ready);

`ifdef RS_AGE_PICK_EN
   // Rank = number of older busy entries; busy ranks stay a dense 0..count-1.
   logic [IDX_W-1:0]           r_rank [ENTRY_NUM];
   logic [ENTRY_NUM*IDX_W-1:0] w_rank_flat;
   logic [IDX_W-1:0]           w_sel_rank;
   logic [IDX_W-1:0]           w_alloc_rank;

   always_comb begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         w_rank_flat[i*IDX_W +: IDX_W] = r_rank[i];
      end
   end

   assign w_sel_rank   = r_rank[w_sel_idx];
   assign w_alloc_rank = IDX_W'(r_count - (w_load ? CNT_W'(1) : CNT_W'(0)));

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < ENTRY_NUM; i++) r_rank[i] <= '0;
      end else begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (w_issue && (w_alloc_idx == IDX_W'(i))) begin
               r_rank[i] <= w_alloc_rank;
            end else if (r_busy[i] && w_load && (r_rank[i] > w_sel_rank)) begin
               r_rank[i] <= r_rank[i] - IDX_W'(1);
            end
         end
      end
   end
`endif

   rs_select #(
      .ENTRY_NUM (ENTRY_NUM)
   ) u_select (
      .i_ready (w_ready),
`ifdef RS_AGE_PICK_EN
      .i_rank  (w_rank_flat),
`endif
      .o_grant (w_grant),
      .o_idx   (w_sel_idx),
      .o_valid (w_sel_valid)
   );

   // ---------------------------------------------------------------- control state
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_busy     <= '0;
         r_count    <= '0;
         r_fu_valid <= 1'b0;
         r_fu_op    <= '0;
         r_fu_vj    <= '0;
         r_fu_vk    <= '0;
         r_fu_dest  <= '0;
         for (int i = 0; i < ENTRY_NUM; i++) begin
            r_qj[i] <= TAG_RDY;
            r_qk[i] <= TAG_RDY;
         end
      end else if (flush) begin
         // Payload of the output register is left as-is; fu_valid masks it.
         r_busy     <= '0;
         r_count    <= '0;
         r_fu_valid <= 1'b0;
      end else begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (w_issue && (w_alloc_idx == IDX_W'(i))) begin
               r_busy[i] <= 1'b1;
               r_qj[i]   <= w_iss_qj;
               r_qk[i]   <= w_iss_qk;
            end else if (r_busy[i]) begin
               if (w_load && w_grant[i]) r_busy[i] <= 1'b0;
               if (w_wk_j_hit[i])        r_qj[i]   <= TAG_RDY;
               if (w_wk_k_hit[i])        r_qk[i]   <= TAG_RDY;
            end
         end

         if (w_load) begin
            r_fu_valid <= 1'b1;
            r_fu_op    <= r_op[w_sel_idx];
            r_fu_vj    <= r_vj[w_sel_idx];
            r_fu_vk    <= r_vk[w_sel_idx];
            r_fu_dest  <= r_dest[w_sel_idx];
         end else if (fu_ready) begin
            r_fu_valid <= 1'b0;
         end

         case ({w_issue, w_load})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------- payload storage
   // NOTE: payload arrays carry no reset; Busy and Q gate every use, so clearing them would only add reset fan-out.
   always_ff @(posedge clk) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
         if (w_issue && (w_alloc_idx == IDX_W'(i))) begin
            r_op[i]   <= issue_op;
            r_vj[i]   <= w_iss_vj;
            r_vk[i]   <= w_iss_vk;
            r_dest[i] <= issue_dest;
         end else if (r_busy[i]) begin
            if (w_wk_j_hit[i]) r_vj[i] <= w_wk_j_data[i];
            if (w_wk_k_hit[i]) r_vk[i] <= w_wk_k_data[i];
         end
      end
   end

   assign fu_valid = r_fu_valid;
   assign fu_op    = r_fu_op;
   assign fu_vj    = r_fu_vj;
   assign fu_vk    = r_fu_vk;
   assign fu_dest  = r_fu_dest;
   assign count    = r_count;

endmodule
